// File: rtl/seg_scan_decoder_if.sv
// Multiplexed 7-segment bus: active-low segments, anodes and decimal point.
// The display block drives it as master; the scan decoder samples it as slave.
interface seg_scan_decoder_if;
  logic [6:0] seg;
  logic [3:0] ga;
  logic       dp;

  modport master (output seg, ga, dp);
  modport slave  (input  seg, ga, dp);
endinterface

// File: rtl/seg_scan_decoder.sv
// Rebuilds four BCD digits from a multiplexed 7-segment scan and flags bad glyphs/anodes/stalls.
// Optional macro SEGDEC_DP_EN: capture per-digit decimal points onto dp_out.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 3,
  parameter int STALE_CYCLES  = 4096
) (
  input  logic                msclk,
  input  logic                reset,
  seg_scan_decoder_if.slave   bus,
  output logic [3:0]          one,
  output logic [3:0]          ten,
  output logic [3:0]          hun,
  output logic [3:0]          thoud,
  output logic                frame_valid,
  output logic                seg_err,
  output logic                ga_err,
  output logic                stale,
  output logic [3:0]          dp_out
);

  localparam int RW = $clog2(STABLE_CYCLES + 1);
  localparam int SW = $clog2(STALE_CYCLES + 1);
  localparam logic [RW-1:0] RUN_MAX   = RW'(STABLE_CYCLES);
  localparam logic [SW-1:0] STALE_MAX = SW'(STALE_CYCLES);

  // Returns {valid, bcd}; anything other than a 0-9 glyph is invalid.
  function automatic logic [4:0] decode_glyph(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b1000000: r = 5'h10;
      7'b1111001: r = 5'h11;
      7'b0100100: r = 5'h12;
      7'b0110000: r = 5'h13;
      7'b0011001: r = 5'h14;
      7'b0010010: r = 5'h15;
      7'b0000010: r = 5'h16;
      7'b1111000: r = 5'h17;
      7'b0000000: r = 5'h18;
      7'b0010000: r = 5'h19;
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  logic [10:0]     sample;
  logic [10:0]     prev_sample;
  logic [RW-1:0]   run_cnt;
  logic [RW-1:0]   run_nxt;
  logic            act;

  logic [3:0]      an;
  logic            an_single;
  logic            an_multi;
  logic [4:0]      glyph;

  logic [3:0]      seen;
  logic [3:0]      seen_nxt;
  logic [3:0][3:0] shadow;
  logic [3:0][3:0] shadow_nxt;
  logic [3:0][3:0] digits;
  logic [3:0][3:0] digits_nxt;
  logic            capture;
  logic            fv_nxt;
  logic            se_nxt;
  logic            ge_nxt;

  logic [SW-1:0]   stale_cnt;
  logic [SW-1:0]   stale_cnt_nxt;
  logic            stale_nxt;

  assign sample = {bus.ga, bus.seg};
  assign an     = ~bus.ga;
  assign glyph  = decode_glyph(bus.seg);

  assign an_single = (an != 4'd0) && ((an & (an - 4'd1)) == 4'd0);
  assign an_multi  = (an != 4'd0) && !an_single;

  // A run acts once: on the edge its length first hits STABLE_CYCLES.
  always_comb begin
    run_nxt = run_cnt;
    if (sample != prev_sample) begin
      run_nxt = RW'(1);
    end else if (run_cnt != RUN_MAX) begin
      run_nxt = run_cnt + 1'b1;
    end
    act = (run_nxt == RUN_MAX) && ((run_cnt != RUN_MAX) || (sample != prev_sample));
  end

  always_comb begin
    seen_nxt   = seen;
    shadow_nxt = shadow;
    digits_nxt = digits;
    capture    = 1'b0;
    fv_nxt     = 1'b0;
    se_nxt     = 1'b0;
    ge_nxt     = 1'b0;
    if (act) begin
      if (an_single) begin
        if (glyph[4]) begin
          capture = 1'b1;
          for (int i = 0; i < 4; i++) begin
            if (an[i]) shadow_nxt[i] = glyph[3:0];
          end
          seen_nxt = seen | an;
          // The digit captured on the completing edge goes straight to the outputs.
          if (seen_nxt == 4'hF) begin
            digits_nxt = shadow_nxt;
            fv_nxt     = 1'b1;
            seen_nxt   = 4'd0;
          end
        end else begin
          se_nxt   = 1'b1;
          seen_nxt = seen & ~an;
        end
      end else if (an_multi) begin
        ge_nxt = 1'b1;
      end
    end
  end

  always_comb begin
    stale_cnt_nxt = stale_cnt;
    stale_nxt     = stale;
    if (capture) begin
      stale_cnt_nxt = '0;
      stale_nxt     = 1'b0;
    end else begin
      if (stale_cnt != STALE_MAX) stale_cnt_nxt = stale_cnt + 1'b1;
      if (stale_cnt_nxt == STALE_MAX) stale_nxt = 1'b1;
    end
  end

  always_ff @(posedge msclk) begin
    if (reset) begin
      prev_sample <= '0;
      run_cnt     <= '0;
      seen        <= '0;
      shadow      <= '0;
      digits      <= '0;
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
      ga_err      <= 1'b0;
      stale_cnt   <= '0;
      stale       <= 1'b0;
    end else begin
      prev_sample <= sample;
      run_cnt     <= run_nxt;
      seen        <= seen_nxt;
      shadow      <= shadow_nxt;
      digits      <= digits_nxt;
      frame_valid <= fv_nxt;
      seg_err     <= se_nxt;
      ga_err      <= ge_nxt;
      stale_cnt   <= stale_cnt_nxt;
      stale       <= stale_nxt;
    end
  end

  assign one   = digits[0];
  assign ten   = digits[1];
  assign hun   = digits[2];
  assign thoud = digits[3];

`ifdef SEGDEC_DP_EN
  logic [3:0] dp_shadow;
  logic [3:0] dp_merged;
  logic [3:0] dp_reg;

  assign dp_merged = (dp_shadow & ~an) | (an & {4{~bus.dp}});

  always_ff @(posedge msclk) begin
    if (reset) begin
      dp_shadow <= '0;
      dp_reg    <= '0;
    end else begin
      if (capture) dp_shadow <= dp_merged;
      if (fv_nxt)  dp_reg    <= dp_merged;
    end
  end

  assign dp_out = dp_reg;
`else
  logic unused_dp;
  assign unused_dp = bus.dp;
  assign dp_out    = 4'b0000;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with a cycle-by-cycle behavioural model
// driven from the raw sample history rather than counters.
module tb_seg_scan_decoder;
  localparam int STABLE = 3;
  localparam int STALE  = 4096;

  logic       msclk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] one, ten, hun, thoud, dp_out;
  logic       frame_valid, seg_err, ga_err, stale;

  seg_scan_decoder_if bus_i();

  seg_scan_decoder #(.STABLE_CYCLES(STABLE), .STALE_CYCLES(STALE)) dut (
    .msclk       (msclk),
    .reset       (reset),
    .bus         (bus_i),
    .one         (one),
    .ten         (ten),
    .hun         (hun),
    .thoud       (thoud),
    .frame_valid (frame_valid),
    .seg_err     (seg_err),
    .ga_err      (ga_err),
    .stale       (stale),
    .dp_out      (dp_out)
  );

  always #5 msclk = ~msclk;

  int total = 0;
  int bad   = 0;
  int n_fv  = 0;
  int n_se  = 0;
  int n_ge  = 0;

  logic [10:0] hist[$];
  logic [3:0]  m_seen;
  logic [3:0]  m_shadow[4];
  logic [3:0]  m_out[4];
  logic [3:0]  m_dpsh, m_dpo;
  bit          m_fv, m_se, m_ge;
  int          m_since;

  function automatic logic [6:0] glyph(int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic [10:0] s;
    int run, zeros, pos, dig;
    bit cap;
    m_fv = 0; m_se = 0; m_ge = 0; cap = 0;
    if (reset) begin
      hist.delete();
      m_seen = 0; m_dpsh = 0; m_dpo = 0; m_since = 0;
      for (int i = 0; i < 4; i++) begin m_shadow[i] = 0; m_out[i] = 0; end
      return;
    end
    s = {bus_i.ga, bus_i.seg};
    hist.push_back(s);
    if (hist.size() > STABLE + 1) void'(hist.pop_front());
    run = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != s) break;
      run++;
    end
    if (run == STABLE) begin
      zeros = 0; pos = 0;
      for (int i = 0; i < 4; i++) if (!bus_i.ga[i]) begin zeros++; pos = i; end
      if (zeros == 1) begin
        dig = -1;
        for (int d = 0; d < 10; d++) if (glyph(d) == bus_i.seg) dig = d;
        if (dig >= 0) begin
          cap = 1;
          m_shadow[pos] = 4'(dig);
          m_seen[pos]   = 1'b1;
          m_dpsh[pos]   = ~bus_i.dp;
          if (m_seen == 4'hF) begin
            for (int i = 0; i < 4; i++) m_out[i] = m_shadow[i];
            m_dpo  = m_dpsh;
            m_fv   = 1;
            m_seen = 0;
          end
        end else begin
          m_se = 1;
          m_seen[pos] = 1'b0;
        end
      end else if (zeros > 1) begin
        m_ge = 1;
      end
    end
    if (cap) m_since = 0;
    else if (m_since < STALE) m_since++;
  endtask

  function automatic logic [3:0] exp_dp();
`ifdef SEGDEC_DP_EN
    return m_dpo;
`else
    return 4'b0000;
`endif
  endfunction

  always @(posedge msclk) begin
    model_step();
    #1;
    chk("cycle_outputs",
        {8'h0, thoud, hun, ten, one, frame_valid, seg_err, ga_err, stale, dp_out},
        {8'h0, m_out[3], m_out[2], m_out[1], m_out[0], m_fv, m_se, m_ge, (m_since >= STALE), exp_dp()});
    if (frame_valid) n_fv++;
    if (seg_err) n_se++;
    if (ga_err) n_ge++;
  end

  task automatic drive(logic [3:0] g, logic [6:0] s, bit d, int n);
    @(negedge msclk);
    bus_i.ga  = g;
    bus_i.seg = s;
    bus_i.dp  = d;
    repeat (n - 1) @(negedge msclk);
  endtask

  task automatic scan(int pos, int d, bit dpv = 1'b1);
    logic [3:0] g;
    g = 4'b0001 << pos;
    drive(~g, glyph(d), dpv, 4);
  endtask

  int fv0;

  initial begin
    bus_i.ga  = 4'hF;
    bus_i.seg = 7'h7F;
    bus_i.dp  = 1'b1;
    reset     = 1'b1;
    repeat (5) @(negedge msclk);
    chk("reset_digits", {16'h0, thoud, hun, ten, one}, 32'h0);
    chk("reset_flags", {24'h0, frame_valid, seg_err, ga_err, stale, dp_out}, 32'h0);
    reset = 1'b0;

    scan(0, 1); scan(1, 2); scan(2, 3); scan(3, 4);
    drive(4'hF, 7'h7F, 1, 2);
    chk("t1_frames", n_fv, 1);
    chk("t1_digits", {thoud, hun, ten, one}, 16'h4321);

    scan(0, 9);
    drive(4'b1101, glyph(0), 1, 1);
    drive(4'b1101, 7'h7F, 1, 1);
    scan(1, 0); scan(2, 7); scan(3, 5);
    drive(4'hF, 7'h7F, 1, 2);
    chk("t2_frames", n_fv, 2);
    chk("t2_digits", {thoud, hun, ten, one}, 16'h5709);
    chk("t2_no_seg_err", n_se, 0);

    scan(0, 4);
    drive(4'b1110, 7'h7F, 1, 4);
    scan(1, 1); scan(2, 2); scan(3, 3);
    chk("t3_seg_err", n_se, 1);
    chk("t3_no_frame", n_fv, 2);
    scan(0, 6);
    drive(4'hF, 7'h7F, 1, 2);
    chk("t3_frames", n_fv, 3);
    chk("t3_digits", {thoud, hun, ten, one}, 16'h3216);

    scan(0, 5); scan(1, 5);
    drive(4'b1100, glyph(8), 1, 4);
    scan(2, 5);
    chk("t4_ga_err", n_ge, 1);
    chk("t4_no_frame", n_fv, 3);
    chk("t4_digits_held", {thoud, hun, ten, one}, 16'h3216);
    scan(3, 5);
    drive(4'hF, 7'h7F, 1, 2);
    chk("t4_frames", n_fv, 4);
    chk("t4_digits", {thoud, hun, ten, one}, 16'h5555);

    drive(4'hF, 7'h7F, 1, STALE + 10);
    chk("t5_stale_set", stale, 1);
    scan(0, 7);
    chk("t5_stale_clr", stale, 0);

    scan(1, 2);
    reset = 1'b1;
    repeat (2) @(negedge msclk);
    reset = 1'b0;
    chk("t6_reset_digits", {thoud, hun, ten, one}, 16'h0);
    fv0 = n_fv;
    scan(0, 8); scan(1, 8); scan(2, 8, 1'b0);
    chk("t6_no_early_frame", n_fv, fv0);
    scan(3, 8);
    drive(4'hF, 7'h7F, 1, 2);
    chk("t6_frames", n_fv, fv0 + 1);
    chk("t6_digits", {thoud, hun, ten, one}, 16'h8888);
`ifdef SEGDEC_DP_EN
    chk("t6_dp_out", dp_out, 4'b0100);
`else
    chk("t6_dp_out", dp_out, 4'b0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
